// File: rtl/seg7_pkg.sv
// Seven-segment glyph constants and nibble decode shared by the scan driver.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam seg7_t SEG_0     = 7'h40;
    localparam seg7_t SEG_1     = 7'h79;
    localparam seg7_t SEG_2     = 7'h24;
    localparam seg7_t SEG_3     = 7'h30;
    localparam seg7_t SEG_4     = 7'h19;
    localparam seg7_t SEG_5     = 7'h12;
    localparam seg7_t SEG_6     = 7'h02;
    localparam seg7_t SEG_7     = 7'h78;
    localparam seg7_t SEG_8     = 7'h00;
    localparam seg7_t SEG_9     = 7'h10;
    localparam seg7_t SEG_DASH  = 7'h3F;
    localparam seg7_t SEG_BLANK = 7'h7F;

    // Non-BCD nibbles (10..15) render as a dash so bad input is visible
    function automatic seg7_t bcd2seg(input logic [3:0] nibble);
        seg7_t glyph;
        case (nibble)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_DASH;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment glyph decoder.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg7_t      seg_c_o
);

    assign seg_c_o = bcd2seg(nib_i);

endmodule

// File: rtl/bcd_seg_scan.sv
// Multiplexed seven-segment scan driver with frame-aligned display updates.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module bcd_seg_scan
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS      = 6,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic                bcd_vld,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an,
    output logic                frame_done
);

    localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned BCD_W = 4 * DIGITS;

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BCD_W-1:0]  pend_q, pend_d;
    logic              pend_f_q, pend_f_d;
    logic [BCD_W-1:0]  disp_q, disp_d;
    seg7_t             seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              frame_done_q;

    logic              tick;
    logic              wrap;
    logic [3:0]        nib;
    seg7_t             glyph;
    logic              blank;

    // Prescaler, digit index and pending/display update sequencing
    always_comb begin
        tick      = (div_cnt_q == DIV_W'(REFRESH_DIV - 1));
        wrap      = tick && (idx_q == IDX_W'(DIGITS - 1));
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        idx_d     = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
        pend_d   = bcd_vld ? bcd_in : pend_q;
        pend_f_d = pend_f_q;
        disp_d   = disp_q;
        if (wrap) begin
            pend_f_d = 1'b0;
            if (bcd_vld) begin
                disp_d = bcd_in;
            end else if (pend_f_q) begin
                disp_d = pend_q;
            end
        end else if (bcd_vld) begin
            pend_f_d = 1'b1;
        end
    end

    // Select the current digit nibble and build the active-low anode pattern
    always_comb begin
        nib  = 4'd0;
        an_d = '1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib     = disp_q[4*i +: 4];
                an_d[i] = 1'b0;
            end
        end
    end

    bcd_to_seg7 u_dec (
        .nib_i   (nib),
        .seg_c_o (glyph)
    );

`ifdef SEG_LZB_EN
    // Blank digit i>=1 when it and every more-significant nibble are zero
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        blank    = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            zero_run = zero_run && (disp_q[4*i +: 4] == 4'd0);
            if ((idx_q == IDX_W'(i)) && zero_run) begin
                blank = 1'b1;
            end
        end
    end
`else
    assign blank = 1'b0;
`endif

    assign seg_d = blank ? SEG_BLANK : glyph;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            pend_q       <= '0;
            pend_f_q     <= 1'b0;
            disp_q       <= '0;
            seg_q        <= SEG_BLANK;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_f_q     <= pend_f_d;
            disp_q       <= disp_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= wrap;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan (DIGITS=4, REFRESH_DIV=4).
module tb_bcd_seg_scan;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned RDIV   = 4;
    localparam int          FRAME  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd_in;
    logic        bcd_vld;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
    } obs_t;

    obs_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] cur_disp;

    always #5 clk = ~clk;

    bcd_seg_scan #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (RDIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .bcd_vld    (bcd_vld),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    // Expected glyph for digit d of display value v
    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
        logic [3:0] n;
        logic [6:0] g;
        n = v[4*d +: 4];
        case (n)
            4'd0: g = 7'h40;
            4'd1: g = 7'h79;
            4'd2: g = 7'h24;
            4'd3: g = 7'h30;
            4'd4: g = 7'h19;
            4'd5: g = 7'h12;
            4'd6: g = 7'h02;
            4'd7: g = 7'h78;
            4'd8: g = 7'h00;
            4'd9: g = 7'h10;
            default: g = 7'h3F;
        endcase
`ifdef SEG_LZB_EN
        if (d >= 1 && (v >> (4*d)) == 16'h0000) g = 7'h7F;
`endif
        return g;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame_done();
        int n = 0;
        while (frame_done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        tests++;
        if (frame_done !== 1'b1) begin
            fails++;
            $display("FAIL frame_done_timeout got=%b want=1", frame_done);
        end
    endtask

    // Starting at a frame_done sample, run one frame checking every cycle.
    // vld strobes driven after sample k are captured at edge k+1; k=15 hits the wrap.
    task automatic run_frame(input string name,
                             input int at1, input logic [15:0] v1,
                             input int at2, input logic [15:0] v2);
        logic [15:0] nxt;
        logic [15:0] pend;
        bit          pset;
        obs_t        e;
        obs_t        o;
        logic [3:0]  one;
        nxt  = cur_disp;
        pend = 16'h0;
        pset = 0;
        one  = 4'b0001;
        if (at1 >= 0 && at1 < 15) begin pend = v1; pset = 1; end
        if (at2 >= 0 && at2 < 15) begin pend = v2; pset = 1; end
        if (at1 == 15)      nxt = v1;
        else if (at2 == 15) nxt = v2;
        else if (pset)      nxt = pend;
        for (int s = 1; s <= FRAME; s++) begin
            int d;
            d     = (s - 1) / 4;
            e.an  = ~(one << d);
            e.seg = exp_seg(cur_disp, d);
            e.fd  = (s == FRAME);
            exp_q.push_back(e);
        end
        for (int s = 0; s <= FRAME; s++) begin
            if (s > 0) begin
                step();
                e = exp_q.pop_front();
                o = '{an: an, seg: seg, fd: frame_done};
                tests++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL %s s=%0d an=%h/%h seg=%h/%h fd=%b/%b (got/want)",
                             name, s, o.an, e.an, o.seg, e.seg, o.fd, e.fd);
                end
            end
            if (s == at1) begin
                bcd_vld = 1'b1; bcd_in = v1;
            end else if (s == at2) begin
                bcd_vld = 1'b1; bcd_in = v2;
            end else begin
                bcd_vld = 1'b0;
            end
        end
        cur_disp = nxt;
    endtask

    task automatic test_reset();
        rst = 1'b1; bcd_vld = 1'b0; bcd_in = 16'h0;
        repeat (3) step();
        tests++; if (an !== 4'hF)         begin fails++; $display("FAIL rst_an got=%h want=f", an); end
        tests++; if (seg !== 7'h7F)       begin fails++; $display("FAIL rst_seg got=%h want=7f", seg); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rst_fd got=%b want=0", frame_done); end
        rst = 1'b0;
        step();
        tests++; if (an !== 4'hE)  begin fails++; $display("FAIL rel_an got=%h want=e", an); end
        tests++; if (seg !== 7'h40) begin fails++; $display("FAIL rel_seg got=%h want=40", seg); end
        cur_disp = 16'h0000;
    endtask

    task automatic test_scan();
        wait_frame_done();
        run_frame("scan0", -1, 16'h0, -1, 16'h0);
        run_frame("scan1", -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_update();
        run_frame("upd_mid",  5, 16'h1234, -1, 16'h0);
        run_frame("upd_show", -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_collision();
        run_frame("coll_wrap", 3, 16'h9999, 15, 16'h0042);
        run_frame("coll_show", -1, 16'h0, -1, 16'h0);
        run_frame("coll_hold", -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_invalid();
        run_frame("inv_load",  7, 16'h00A5, -1, 16'h0);
        run_frame("inv_00a5", 10, 16'hA005, -1, 16'h0);
        run_frame("inv_a005", -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_load", 0, 16'h8765, 14, 16'h1098);
        run_frame("b2b_last", -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_async_reset();
        for (int s = 1; s <= 9; s++) begin
            step();
            bcd_vld = (s == 2);
            bcd_in  = 16'h5678;
        end
        tests++; if (an !== 4'hB) begin fails++; $display("FAIL ar_pre_an got=%h want=b", an); end
        #2 rst = 1'b1;
        #1;
        tests++; if (an !== 4'hF)         begin fails++; $display("FAIL ar_an got=%h want=f", an); end
        tests++; if (seg !== 7'h7F)       begin fails++; $display("FAIL ar_seg got=%h want=7f", seg); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL ar_fd got=%b want=0", frame_done); end
        step();
        step();
        rst = 1'b0;
        step();
        tests++; if (an !== 4'hE)   begin fails++; $display("FAIL ar_rel_an got=%h want=e", an); end
        tests++; if (seg !== 7'h40) begin fails++; $display("FAIL ar_rel_seg got=%h want=40", seg); end
        cur_disp = 16'h0000;
        wait_frame_done();
        run_frame("ar_frame0", -1, 16'h0, -1, 16'h0);
        run_frame("ar_frame1", -1, 16'h0, -1, 16'h0);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_update();
        test_collision();
        test_invalid();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
